// File: rtl/banked_ram_arbiter.sv
// Arbitrates clients A and B onto a dual-ported banked RAM with same-bank conflict stalls,
// B aging priority and 1-cycle read response routing. Optional counters: BANKED_RAM_ARB_STATS_EN.
module banked_ram_arbiter #(
   parameter int TAG_W      = 2,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 13,
   parameter int AGE_MAX    = 4,
   parameter int STAT_W     = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_req_valid,
   output logic                  a_req_ready,
   input  logic                  a_req_we,
   input  logic [ADDR_WIDTH-1:0] a_req_addr,
   input  logic [DATA_WIDTH-1:0] a_req_wdata,
   output logic                  a_rsp_valid,
   output logic [DATA_WIDTH-1:0] a_rsp_data,
   input  logic                  b_req_valid,
   output logic                  b_req_ready,
   input  logic                  b_req_we,
   input  logic [ADDR_WIDTH-1:0] b_req_addr,
   input  logic [DATA_WIDTH-1:0] b_req_wdata,
   output logic                  b_rsp_valid,
   output logic [DATA_WIDTH-1:0] b_rsp_data,
   output logic                  ram_read_req_a,
   output logic [ADDR_WIDTH-1:0] ram_read_addr_a,
   input  logic [DATA_WIDTH-1:0] ram_read_data_a,
   output logic                  ram_write_req_a,
   output logic [ADDR_WIDTH-1:0] ram_write_addr_a,
   output logic [DATA_WIDTH-1:0] ram_write_data_a,
   output logic                  ram_read_req_b,
   output logic [ADDR_WIDTH-1:0] ram_read_addr_b,
   input  logic [DATA_WIDTH-1:0] ram_read_data_b,
   output logic                  ram_write_req_b,
   output logic [ADDR_WIDTH-1:0] ram_write_addr_b,
   output logic [DATA_WIDTH-1:0] ram_write_data_b
`ifdef BANKED_RAM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]     stat_conflicts,
   output logic [STAT_W-1:0]     stat_b_aged
`endif
);

   localparam int AGE_W = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);

   logic [AGE_W-1:0] age_cnt;
   logic [TAG_W-1:0] a_tag, b_tag;
   logic             conflict, b_prio, a_acc, b_acc;
   logic             a_rsp_q, b_rsp_q;

   assign a_tag = a_req_addr[ADDR_WIDTH-1 -: TAG_W];
   assign b_tag = b_req_addr[ADDR_WIDTH-1 -: TAG_W];

   assign conflict = a_req_valid && b_req_valid && (a_req_we == b_req_we) && (a_tag == b_tag);
   assign b_prio   = (age_cnt == AGE_W'(AGE_MAX));

   // Handshake: a transfer happens in a cycle where valid && ready; ready is combinational
   // from both valids and drops only for the loser of a same-bank, same-direction conflict.
   assign a_req_ready = !reset && !(conflict && b_prio);
   assign b_req_ready = !reset && !(conflict && !b_prio);

   assign a_acc = a_req_valid && a_req_ready;
   assign b_acc = b_req_valid && b_req_ready;

   assign ram_read_req_a   = a_acc && !a_req_we;
   assign ram_write_req_a  = a_acc && a_req_we;
   assign ram_read_addr_a  = a_req_addr;
   assign ram_write_addr_a = a_req_addr;
   assign ram_write_data_a = a_req_wdata;

   assign ram_read_req_b   = b_acc && !b_req_we;
   assign ram_write_req_b  = b_acc && b_req_we;
   assign ram_read_addr_b  = b_req_addr;
   assign ram_write_addr_b = b_req_addr;
   assign ram_write_data_b = b_req_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         age_cnt <= '0;
         a_rsp_q <= 1'b0;
         b_rsp_q <= 1'b0;
      end else begin
         a_rsp_q <= ram_read_req_a;
         b_rsp_q <= ram_read_req_b;
         if (b_acc)
            age_cnt <= '0;
         else if (conflict && !b_prio)
            age_cnt <= age_cnt + AGE_W'(1);
      end
   end

   // Gating with reset drops a response that would otherwise appear in the reset cycle itself.
   assign a_rsp_valid = a_rsp_q && !reset;
   assign b_rsp_valid = b_rsp_q && !reset;
   assign a_rsp_data  = ram_read_data_a;
   assign b_rsp_data  = ram_read_data_b;

`ifdef BANKED_RAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_conflicts <= '0;
         stat_b_aged    <= '0;
      end else begin
         if (conflict && (stat_conflicts != '1))
            stat_conflicts <= stat_conflicts + STAT_W'(1);
         if (conflict && b_prio && (stat_b_aged != '1))
            stat_b_aged <= stat_b_aged + STAT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_banked_ram_arbiter.sv
// Directed bench for banked_ram_arbiter with a read-before-write RAM model and a response queue.
module tb_banked_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
   logic [12:0] a_req_addr;
   logic [15:0] a_req_wdata, a_rsp_data;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
   logic [12:0] b_req_addr;
   logic [15:0] b_req_wdata, b_rsp_data;
   logic        ram_read_req_a, ram_write_req_a, ram_read_req_b, ram_write_req_b;
   logic [12:0] ram_read_addr_a, ram_write_addr_a, ram_read_addr_b, ram_write_addr_b;
   logic [15:0] ram_read_data_a, ram_write_data_a, ram_read_data_b, ram_write_data_b;
`ifdef BANKED_RAM_ARB_STATS_EN
   logic [15:0] stat_conflicts, stat_b_aged;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int a_rsp_cnt = 0;
   int b_rsp_cnt = 0;
   logic a_pend = 1'b0;
   logic b_pend = 1'b0;
   logic [15:0] exp_a_q[$];
   logic [15:0] exp_b_q[$];

   banked_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
      .ram_read_req_a(ram_read_req_a), .ram_read_addr_a(ram_read_addr_a),
      .ram_read_data_a(ram_read_data_a),
      .ram_write_req_a(ram_write_req_a), .ram_write_addr_a(ram_write_addr_a),
      .ram_write_data_a(ram_write_data_a),
      .ram_read_req_b(ram_read_req_b), .ram_read_addr_b(ram_read_addr_b),
      .ram_read_data_b(ram_read_data_b),
      .ram_write_req_b(ram_write_req_b), .ram_write_addr_b(ram_write_addr_b),
      .ram_write_data_b(ram_write_data_b)
`ifdef BANKED_RAM_ARB_STATS_EN
      ,
      .stat_conflicts(stat_conflicts), .stat_b_aged(stat_b_aged)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- RAM model: unwritten words read as pat(addr), reads see old data ----------------
   logic [15:0] mem [0:8191];
   bit          wflag [0:8191];

   function automatic logic [15:0] pat(input logic [12:0] a);
      return {3'b000, a} ^ 16'hA5A5;
   endfunction

   function automatic logic [15:0] ram_word(input logic [12:0] a);
      return wflag[a] ? mem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      if (ram_read_req_a) ram_read_data_a <= ram_word(ram_read_addr_a);
      if (ram_read_req_b) ram_read_data_b <= ram_word(ram_read_addr_b);
      if (ram_write_req_a) begin
         mem[ram_write_addr_a]   <= ram_write_data_a;
         wflag[ram_write_addr_a] <= 1'b1;
      end
      if (ram_write_req_b) begin
         mem[ram_write_addr_b]   <= ram_write_data_b;
         wflag[ram_write_addr_b] <= 1'b1;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and score the responses due from the previous cycle.
   task automatic tick();
      @(negedge clk);
      chk("a_rsp_valid", 32'(a_rsp_valid), 32'(a_pend));
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(b_pend));
      if (a_rsp_valid) a_rsp_cnt++;
      if (b_rsp_valid) b_rsp_cnt++;
      if (a_pend && exp_a_q.size() > 0) chk("a_rsp_data", 32'(a_rsp_data), 32'(exp_a_q.pop_front()));
      if (b_pend && exp_b_q.size() > 0) chk("b_rsp_data", 32'(b_rsp_data), 32'(exp_b_q.pop_front()));
      a_pend = 1'b0;
      b_pend = 1'b0;
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic av, input logic aw, input logic [12:0] aa, input logic [15:0] ad,
                        input logic bv, input logic bw, input logic [12:0] ba, input logic [15:0] bd,
                        input logic ea, input logic eb, input logic [15:0] xa, input logic [15:0] xb);
      a_req_valid = av; a_req_we = aw; a_req_addr = aa; a_req_wdata = ad;
      b_req_valid = bv; b_req_we = bw; b_req_addr = ba; b_req_wdata = bd;
      #1;
      chk("a_req_ready", 32'(a_req_ready), 32'(ea));
      chk("b_req_ready", 32'(b_req_ready), 32'(eb));
      chk("ram_read_req_a", 32'(ram_read_req_a), 32'(av && !aw && ea));
      chk("ram_write_req_a", 32'(ram_write_req_a), 32'(av && aw && ea));
      chk("ram_read_req_b", 32'(ram_read_req_b), 32'(bv && !bw && eb));
      chk("ram_write_req_b", 32'(ram_write_req_b), 32'(bv && bw && eb));
      if (av) chk("ram_addr_a", 32'(aw ? ram_write_addr_a : ram_read_addr_a), 32'(aa));
      if (bv) chk("ram_addr_b", 32'(bw ? ram_write_addr_b : ram_read_addr_b), 32'(ba));
      if (av && aw) chk("ram_wdata_a", 32'(ram_write_data_a), 32'(ad));
      if (bv && bw) chk("ram_wdata_b", 32'(ram_write_data_b), 32'(bd));
      if (av && !aw && ea) begin a_pend = 1'b1; exp_a_q.push_back(xa); end
      if (bv && !bw && eb) begin b_pend = 1'b1; exp_b_q.push_back(xb); end
   endtask

   task automatic idle();
      drive(0, 0, 13'h0, 16'h0, 0, 0, 13'h0, 16'h0, !reset, !reset, 16'h0, 16'h0);
   endtask

   // Both clients read bank 1 every cycle; B must lose 4 times, win on the 5th, and repeat.
   task automatic contend_bank1(input int n);
      int k = 0;
      for (int i = 0; i < n; i++) begin
         logic eb;
         eb = ((i % 5) == 4);
         tick();
         drive(1, 0, 13'h0800 + 13'(i), 16'h0, 1, 0, 13'h0900 + 13'(k), 16'h0,
               !eb, eb, pat(13'h0800 + 13'(i)), pat(13'h0900 + 13'(k)));
         if (eb) k++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      // Requests present during reset are neither accepted nor forwarded.
      drive(1, 0, 13'h0010, 16'h0, 1, 1, 13'h0010, 16'h1234, 0, 0, 16'h0, 16'h0);
      chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);

      // 1: same address, A reads while B writes -> both proceed, read returns old value.
      tick();
      reset = 1'b0;
      drive(1, 0, 13'h0010, 16'h0, 1, 1, 13'h0010, 16'h1234, 1, 1, 16'hA5B5, 16'h0);
      tick();
      drive(1, 0, 13'h0010, 16'h0, 0, 0, 13'h0, 16'h0, 1, 1, 16'h1234, 16'h0);

      // 2: both write bank 0 -> A wins, B retries next cycle.
      tick();
      drive(1, 1, 13'h0000, 16'h1111, 1, 1, 13'h0005, 16'h2222, 1, 0, 16'h0, 16'h0);
      tick();
      drive(0, 0, 13'h0, 16'h0, 1, 1, 13'h0005, 16'h2222, 1, 1, 16'h0, 16'h0);
      tick();
      drive(1, 0, 13'h0000, 16'h0, 0, 0, 13'h0, 16'h0, 1, 1, 16'h1111, 16'h0);
      tick();
      drive(1, 0, 13'h0005, 16'h0, 0, 0, 13'h0, 16'h0, 1, 1, 16'h2222, 16'h0);

      // 3: continuous bank-1 read conflict; a full 4-cycle stall also shows age was cleared in 2.
      contend_bank1(10);

      // 4: different banks, 8 back-to-back reads each.
      tick();
      idle();
      tick();
      a_rsp_cnt = 0;
      b_rsp_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 13'h0100 + 13'(i), 16'h0, 1, 0, 13'h1800 + 13'(i), 16'h0,
               1, 1, pat(13'h0100 + 13'(i)), pat(13'h1800 + 13'(i)));
         tick();
      end
      idle();
      chk("s4_a_rsp_count", 32'(a_rsp_cnt), 32'd8);
      chk("s4_b_rsp_count", 32'(b_rsp_cnt), 32'd8);

      // 5: build some age, then reset the cycle after an accepted A read.
      contend_bank1(2);
      tick();
      drive(1, 0, 13'h0200, 16'h0, 0, 0, 13'h0, 16'h0, 1, 1, pat(13'h0200), 16'h0);
      @(negedge clk);
      reset = 1'b1;
      a_pend = 1'b0;
      b_pend = 1'b0;
      exp_a_q.delete();
      exp_b_q.delete();
      idle();
      chk("s5_a_rsp_in_reset", 32'(a_rsp_valid), 32'd0);
      tick();
      reset = 1'b0;
      idle();
      tick();
      idle();

      // 6: age restarts at 0 after reset; B again waits the full 4 cycles.
      contend_bank1(10);
      tick();
      idle();
`ifdef BANKED_RAM_ARB_STATS_EN
      chk("stat_conflicts", 32'(stat_conflicts), 32'd10);
      chk("stat_b_aged", 32'(stat_b_aged), 32'd2);
`endif
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
